// File: rtl/sipo_loader.sv
// sipo_loader
//   Builds a WIDTH-bit word from a framed serial bit stream and hands it to a
//   downstream enable-gated D-register bank. The word appears on o_d_out with a
//   one-cycle o_load_en strobe. Frames that are aborted by a restart or a
//   timeout raise the sticky o_err flag.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    frame start request, sampled every cycle
//   i_sdi      serial data bit
//   i_sdi_vld  i_sdi carries a valid bit this cycle
//   o_d_out    assembled word, registered, held between loads
//   o_load_en  one-cycle strobe marking a new o_d_out
//   o_busy     high while shifting or loading
//   o_err      sticky abort flag
//
// States
//   state    | meaning
//   ST_IDLE  | waiting for i_start; serial input ignored
//   ST_SHIFT | collecting bits, watching for restart and timeout
//   ST_LOAD  | one cycle presenting the new word with o_load_en
module sipo_loader #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sdi,
  input  logic             i_sdi_vld,
  output logic [WIDTH-1:0] o_d_out,
  output logic             o_load_en,
  output logic             o_busy,
  output logic             o_err
);

  localparam int BW = $clog2(WIDTH);
  // Keep the timeout counter at least one bit wide when the timeout is disabled.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [TW-1:0] LAST_TO  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]    r_bit_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic [WIDTH-1:0] w_sr_next;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sr_next = {r_sr[WIDTH-2:0], i_sdi};
    end else begin : g_lsb_first
      assign w_sr_next = {i_sdi, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      o_d_out   <= '0;
      o_load_en <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_load_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_busy <= 1'b0;
          if (i_start) begin
            r_state   <= ST_SHIFT;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            o_err     <= 1'b0;
            o_busy    <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (i_start) begin
            // Restart drops any bit presented in the same cycle.
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            o_err     <= 1'b1;
          end else if (i_sdi_vld) begin
            r_sr     <= w_sr_next;
            r_to_cnt <= '0;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              o_d_out   <= w_sr_next;
              o_load_en <= 1'b1;
              r_state   <= ST_LOAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (TIMEOUT > 0) begin
            if (r_to_cnt == LAST_TO) begin
              r_to_cnt <= '0;
              r_state  <= ST_IDLE;
              o_busy   <= 1'b0;
              o_err    <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (i_start) begin
            // Back-to-back frame: the next START overlaps this cycle.
            r_state   <= ST_SHIFT;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            o_err     <= 1'b0;
            o_busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_loader.sv
module tb_sipo_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sdi;
  logic       sdi_vld;
  logic [2:0] m_d_out, l_d_out;
  logic       m_load_en, l_load_en;
  logic       m_busy, l_busy;
  logic       m_err, l_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] word;
    logic       err;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];

  sipo_loader #(.WIDTH(3), .MSB_FIRST(1'b1), .TIMEOUT(15)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sdi(sdi), .i_sdi_vld(sdi_vld),
    .o_d_out(m_d_out), .o_load_en(m_load_en), .o_busy(m_busy), .o_err(m_err)
  );

  sipo_loader #(.WIDTH(3), .MSB_FIRST(1'b0), .TIMEOUT(15)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sdi(sdi), .i_sdi_vld(sdi_vld),
    .o_d_out(l_d_out), .o_load_en(l_load_en), .o_busy(l_busy), .o_err(l_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every load strobe pops the oldest expected word for that instance.
  logic m_prev_load = 1'b0;
  logic l_prev_load = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m_load_en) begin
        if (q_m.size() == 0) begin
          check("msb_unexpected_load", 32'd1, 32'd0);
        end else begin
          e = q_m.pop_front();
          check("msb_d_out", {29'd0, m_d_out}, {29'd0, e.word});
          check("msb_err_at_load", {31'd0, m_err}, {31'd0, e.err});
          check("msb_busy_at_load", {31'd0, m_busy}, 32'd1);
        end
        check("msb_load_twice", {31'd0, m_prev_load}, 32'd0);
      end
      if (l_load_en) begin
        if (q_l.size() == 0) begin
          check("lsb_unexpected_load", 32'd1, 32'd0);
        end else begin
          e = q_l.pop_front();
          check("lsb_d_out", {29'd0, l_d_out}, {29'd0, e.word});
          check("lsb_err_at_load", {31'd0, l_err}, {31'd0, e.err});
        end
        check("lsb_load_twice", {31'd0, l_prev_load}, 32'd0);
      end
    end
    m_prev_load = m_load_en;
    l_prev_load = l_load_en;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sdi     = b;
    sdi_vld = 1'b1;
    tick(1);
    sdi_vld = 1'b0;
    sdi     = 1'b0;
  endtask

  // Sends a full frame; gap = empty cycles inserted between bits.
  task automatic frame(input logic [2:0] bits, input int gap,
                       input logic [2:0] exp_m, input logic [2:0] exp_l, input logic exp_err);
    exp_t e;
    do_start();
    for (int i = 2; i >= 0; i--) begin
      if (i == 0) begin
        e.word = exp_m; e.err = exp_err; q_m.push_back(e);
        e.word = exp_l; q_l.push_back(e);
      end
      send_bit(bits[i]);
      if (i != 0) tick(gap);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    sdi     = 1'b0;
    sdi_vld = 1'b0;
    tick(3);
    check("rst_d_out", {29'd0, m_d_out}, 32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_err", {31'd0, m_err}, 32'd0);
    check("rst_load_en", {31'd0, m_load_en}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: bits 1,0,1 contiguous
    frame(3'b101, 0, 3'b101, 3'b101, 1'b0);
    check("t1_load_en", {31'd0, m_load_en}, 32'd1);
    check("t1_busy_in_load", {31'd0, m_busy}, 32'd1);
    tick(1);
    check("t1_busy_after", {31'd0, m_busy}, 32'd0);
    check("t1_load_en_after", {31'd0, m_load_en}, 32'd0);
    check("t1_err", {31'd0, m_err}, 32'd0);
    tick(2);

    // 2: bits 1,1,0 -> lsb-first instance sees 3'b011
    frame(3'b110, 0, 3'b110, 3'b011, 1'b0);
    tick(3);

    // 3: bits 0,1,1 with 5-cycle gaps
    frame(3'b011, 5, 3'b011, 3'b110, 1'b0);
    tick(1);
    check("t3_err", {31'd0, m_err}, 32'd0);
    tick(2);

    // 4: restart after two bits, then bits 0,0,1
    do_start();
    send_bit(1'b1);
    send_bit(1'b1);
    check("t4_err_before", {31'd0, m_err}, 32'd0);
    start = 1'b1;
    sdi = 1'b1; sdi_vld = 1'b1;   // bit dropped: START has priority
    tick(1);
    start = 1'b0; sdi_vld = 1'b0; sdi = 1'b0;
    check("t4_err_restart", {31'd0, m_err}, 32'd1);
    check("t4_busy_restart", {31'd0, m_busy}, 32'd1);
    begin
      exp_t e;
      e.word = 3'b001; e.err = 1'b1; q_m.push_back(e);
      e.word = 3'b100; q_l.push_back(e);
    end
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(3);
    check("t4_err_sticky", {31'd0, m_err}, 32'd1);
    check("t4_lsb_err_sticky", {31'd0, l_err}, 32'd1);

    // 5: D_OUT=101, then timeout after one bit
    frame(3'b101, 0, 3'b101, 3'b101, 1'b0);
    tick(2);
    do_start();
    check("t5_err_cleared", {31'd0, m_err}, 32'd0);
    send_bit(1'b1);
    tick(14);
    check("t5_busy_before_to", {31'd0, m_busy}, 32'd1);
    tick(1);
    check("t5_busy_to", {31'd0, m_busy}, 32'd0);
    check("t5_err_to", {31'd0, m_err}, 32'd1);
    check("t5_d_out_held", {29'd0, m_d_out}, 32'd5);
    tick(2);

    // 6: async reset mid-frame, between edges
    do_start();
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_d_out", {29'd0, m_d_out}, 32'd0);
    check("t6_busy", {31'd0, m_busy}, 32'd0);
    check("t6_err", {31'd0, m_err}, 32'd0);
    check("t6_lsb_d_out", {29'd0, l_d_out}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send_bit(1'b1);             // ignored in IDLE
    send_bit(1'b1);
    send_bit(1'b1);
    tick(2);
    check("t6_busy_idle", {31'd0, m_busy}, 32'd0);
    frame(3'b010, 0, 3'b010, 3'b010, 1'b0);
    tick(4);

    check("q_msb_empty", q_m.size(), 32'd0);
    check("q_lsb_empty", q_l.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
